video_timing_gen: RTL and testbench

Generates 640x480@60 raster timing from the 25 MHz pixel clock produced by the video PLL, and drives the panel/VGA pins. Issues an ahead-of-time pixel request (x, y) to the game renderer and aligns the returned RGB565 data with HS/VS/DE, so renderer read latency is hidden. Sits directly downstream of the PLL and upstream of the output pins.

---
 rtl/video_timing_gen.sv | 214 +++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: 640x480@60 raster timing from the 25 MHz pixel clock.
// Issues (x, y) pixel requests FETCH_LAT cycles ahead of the panel and
// realigns the returned RGB565 data with HS/VS/DE.
// Optional build macro: VIDEO_TEST_PATTERN_EN replaces renderer data with
// eight vertical colour bars derived from the delayed request column.
module video_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   FETCH_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] pix_rgb_i,
  output logic        req,
  output logic [11:0] req_x,
  output logic [11:0] req_y,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_BEG_C = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END_C = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_BEG_C = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END_C = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;

  logic        req_q, req_d;
  logic        frame_start_q, frame_start_d;
  logic [11:0] req_x_q, req_x_d;
  logic [11:0] req_y_q, req_y_d;
  logic        hs_stg_q, hs_stg_d;
  logic        vs_stg_q, vs_stg_d;

  logic [FETCH_LAT-1:0] de_pipe_q, de_pipe_d;
  logic [FETCH_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [FETCH_LAT-1:0] vs_pipe_q, vs_pipe_d;
  logic                 de_tail, hs_tail, vs_tail;

  logic [15:0] pix_sel;

  logic        vga_de_q, vga_de_d;
  logic        vga_hs_q, vga_hs_d;
  logic        vga_vs_q, vga_vs_d;
  logic [15:0] vga_rgb_q, vga_rgb_d;

  // Raster counters; disabling snaps back to the origin so re-enable never resumes.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST_C) ? 12'd0 : v_cnt_q + 12'd1;
    end else begin
      h_cnt_d = h_cnt_q + 12'd1;
    end
  end

  // Request stage and raw sync decode, both one register after the counters.
  always_comb begin
    req_d         = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C) && en;
    req_x_d       = req_x_q;
    req_y_d       = req_y_q;
    if (req_d) begin
      req_x_d = h_cnt_q;
      req_y_d = v_cnt_q;
    end
    frame_start_d = req_d && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    hs_stg_d      = (h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C);
    vs_stg_d      = (v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C);
  end

  // Delay line matching renderer latency; the tail lines up with pix_rgb_i.
  always_comb begin
    de_pipe_d    = de_pipe_q << 1;
    hs_pipe_d    = hs_pipe_q << 1;
    vs_pipe_d    = vs_pipe_q << 1;
    de_pipe_d[0] = req_q;
    hs_pipe_d[0] = hs_stg_q;
    vs_pipe_d[0] = vs_stg_q;
  end

  assign de_tail = de_pipe_q[FETCH_LAT-1];
  assign hs_tail = hs_pipe_q[FETCH_LAT-1];
  assign vs_tail = vs_pipe_q[FETCH_LAT-1];

`ifdef VIDEO_TEST_PATTERN_EN
  localparam logic [11:0] BAR_W_C = 12'(H_ACTIVE / 8);

  logic [11:0] x_pipe_q [FETCH_LAT];
  logic [11:0] x_pipe_d [FETCH_LAT];
  logic [11:0] bar;
  logic        unused_pix;

  // Renderer data is ignored in pattern builds.
  assign unused_pix = ^pix_rgb_i;

  // Column travels alongside req so the bar lines up with the emitted pixel.
  always_comb begin
    x_pipe_d[0] = req_x_q;
    for (int i = 1; i < FETCH_LAT; i++) x_pipe_d[i] = x_pipe_q[i-1];
  end

  // Column delay registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_LAT; i++) x_pipe_q[i] <= '0;
    end else begin
      x_pipe_q <= x_pipe_d;
    end
  end

  // Eight equal-width colour bars across the active line.
  always_comb begin
    bar = x_pipe_q[FETCH_LAT-1] / BAR_W_C;
    case (bar)
      12'd0:   pix_sel = 16'hFFFF;
      12'd1:   pix_sel = 16'hFFE0;
      12'd2:   pix_sel = 16'h07FF;
      12'd3:   pix_sel = 16'h07E0;
      12'd4:   pix_sel = 16'hF81F;
      12'd5:   pix_sel = 16'hF800;
      12'd6:   pix_sel = 16'h001F;
      default: pix_sel = 16'h0000;
    endcase
  end
`else
  assign pix_sel = pix_rgb_i;
`endif

  // Output stage: pins blank outside the active area, syncs at configured polarity.
  always_comb begin
    vga_de_d  = de_tail;
    vga_rgb_d = de_tail ? pix_sel : 16'h0000;
    vga_hs_d  = hs_tail ? SYNC_POL : ~SYNC_POL;
    vga_vs_d  = vs_tail ? SYNC_POL : ~SYNC_POL;
  end

  // Counter and request-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      req_q         <= 1'b0;
      frame_start_q <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      hs_stg_q      <= 1'b0;
      vs_stg_q      <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      req_q         <= req_d;
      frame_start_q <= frame_start_d;
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      hs_stg_q      <= hs_stg_d;
      vs_stg_q      <= vs_stg_d;
    end
  end

  // Delay line and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_pipe_q <= '0;
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
      vga_de_q  <= 1'b0;
      vga_hs_q  <= ~SYNC_POL;
      vga_vs_q  <= ~SYNC_POL;
      vga_rgb_q <= '0;
    end else begin
      de_pipe_q <= de_pipe_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      vga_de_q  <= vga_de_d;
      vga_hs_q  <= vga_hs_d;
      vga_vs_q  <= vga_vs_d;
      vga_rgb_q <= vga_rgb_d;
    end
  end

  assign req         = req_q;
  assign req_x       = req_x_q;
  assign req_y       = req_y_q;
  assign frame_start = frame_start_q;
  assign vga_de      = vga_de_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_rgb     = vga_rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: full-size 640x480 instance (FETCH_LAT=2) and a
// shrunken-raster instance (FETCH_LAT=5) so whole frames fit a short run.
// A raster model pushes expected pin values into per-instance queues; they are
// popped when the pixel is due at the pins.
module tb_video_timing_gen;

  localparam int BHA = 16, BHFP = 2, BHS = 4, BHBP = 3;
  localparam int BVA = 6,  BVFP = 1, BVS = 2, BVBP = 1;
  localparam int BFL = 5;

  // model parameters per instance (0 = full size, 1 = small)
  int p_ha  [2] = '{640, BHA};
  int p_hfp [2] = '{16, BHFP};
  int p_hs  [2] = '{96, BHS};
  int p_ht  [2] = '{800, BHA + BHFP + BHS + BHBP};
  int p_va  [2] = '{480, BVA};
  int p_vfp [2] = '{10, BVFP};
  int p_vs  [2] = '{2, BVS};
  int p_vt  [2] = '{525, BVA + BVFP + BVS + BVBP};
  int p_fl  [2] = '{2, BFL};

  // hand-derived timing constants
  int c_lat   [2] = '{3, 6};
  int c_delen [2] = '{640, 16};
  int c_hslen [2] = '{96, 4};
  int c_de2hs [2] = '{656, 18};
  int c_per   [2] = '{800, 25};
  int c_vslen [2] = '{1600, 50};
  int c_frame [2] = '{420000, 250};
  string nm   [2] = '{"a", "b"};

  logic        clk, rst_n, en;
  logic        req [2];
  logic [11:0] rx  [2];
  logic [11:0] ry  [2];
  logic        fs  [2];
  logic        hs  [2];
  logic        vs  [2];
  logic        de  [2];
  logic [15:0] rgb [2];
  logic [15:0] pix [2];

  video_timing_gen u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_rgb_i(pix[0]),
    .req(req[0]), .req_x(rx[0]), .req_y(ry[0]), .frame_start(fs[0]),
    .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_de(de[0]), .vga_rgb(rgb[0])
  );

  video_timing_gen #(
    .H_ACTIVE(BHA), .H_FP(BHFP), .H_SYNC(BHS), .H_BP(BHBP),
    .V_ACTIVE(BVA), .V_FP(BVFP), .V_SYNC(BVS), .V_BP(BVBP),
    .SYNC_POL(1'b0), .FETCH_LAT(BFL)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_rgb_i(pix[1]),
    .req(req[1]), .req_x(rx[1]), .req_y(ry[1]), .frame_start(fs[1]),
    .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_de(de[1]), .vga_rgb(rgb[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // renderer models: data answers the request exactly FETCH_LAT cycles later
  logic [15:0] ra [2];
  logic [15:0] rb [BFL];
  always @(posedge clk) begin
    ra[1] <= ra[0];
    ra[0] <= req[0] ? {ry[0][4:0], rx[0][10:0]} : 16'hBEEF;
    for (int k = BFL - 1; k > 0; k--) rb[k] <= rb[k-1];
    rb[0] <= req[1] ? {ry[1][4:0], rx[1][10:0]} : 16'hBEEF;
  end
  assign pix[0] = ra[1];
  assign pix[1] = rb[BFL-1];

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic string tg(input int i, input string s);
    return {nm[i], s};
  endfunction

  function automatic logic [15:0] bar_col(input int x, input int ha);
    case (x / (ha / 8))
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] exp_pix(input int x, input int y, input int ha);
`ifdef VIDEO_TEST_PATTERN_EN
    return bar_col(x, ha);
`else
    return {y[4:0], x[10:0]};
`endif
  endfunction

  typedef struct {
    int          due;
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
  } exp_t;

  exp_t        sbq [2][$];
  int          t   [2];
  logic        ereq[2];
  logic        efs [2];
  logic [11:0] ex  [2];
  logic [11:0] ey  [2];

  // measurement state
  logic meas_on = 1'b0;
  logic pv_req[2], pv_de[2], pv_hs[2], pv_vs[2];
  int   r_rise[2], d_rise[2], f_last[2], de_run[2], hs_run[2], vs_run[2];

  task automatic mon(input int i);
    exp_t e;
    int   h, v;
    logic act;
    if (!rst_n) begin
      chk(tg(i, ".rst_req"), req[i], 0);
      chk(tg(i, ".rst_x"),   rx[i], 0);
      chk(tg(i, ".rst_y"),   ry[i], 0);
      chk(tg(i, ".rst_fs"),  fs[i], 0);
      chk(tg(i, ".rst_de"),  de[i], 0);
      chk(tg(i, ".rst_hs"),  hs[i], 1);
      chk(tg(i, ".rst_vs"),  vs[i], 1);
      chk(tg(i, ".rst_rgb"), rgb[i], 0);
      sbq[i].delete();
      t[i] = 0; ereq[i] = 0; efs[i] = 0; ex[i] = 0; ey[i] = 0;
      pv_req[i] = 0; pv_de[i] = 0; pv_hs[i] = 1; pv_vs[i] = 1;
      return;
    end
    // request side
    chk(tg(i, ".req"), req[i], ereq[i]);
    chk(tg(i, ".req_x"), rx[i], ex[i]);
    chk(tg(i, ".req_y"), ry[i], ey[i]);
    chk(tg(i, ".fs"), fs[i], efs[i]);
    // pin side
    e.due = 0; e.de = 0; e.hs = 1; e.vs = 1; e.rgb = '0;
    if (sbq[i].size() > 0 && sbq[i][0].due == cyc) e = sbq[i].pop_front();
    chk(tg(i, ".de"), de[i], e.de);
    chk(tg(i, ".hs"), hs[i], e.hs);
    chk(tg(i, ".vs"), vs[i], e.vs);
    chk(tg(i, ".rgb"), rgb[i], e.rgb);
    // interval measurements against hand-derived constants
    if (meas_on) begin
      if (req[i] && !pv_req[i]) r_rise[i] = cyc;
      if (de[i] && !pv_de[i]) begin
        if (r_rise[i] >= 0) chk(tg(i, ".lat"), cyc - r_rise[i], c_lat[i]);
        if (i == 0 && d_rise[i] >= 0) chk(tg(i, ".line_per"), cyc - d_rise[i], c_per[i]);
        d_rise[i] = cyc;
      end
      if (de[i]) de_run[i]++;
      else if (pv_de[i]) begin
        chk(tg(i, ".de_len"), de_run[i], c_delen[i]);
        de_run[i] = 0;
      end
      if (!hs[i]) begin
        if (pv_hs[i] && d_rise[i] >= 0 && cyc - d_rise[i] < c_per[i])
          chk(tg(i, ".de2hs"), cyc - d_rise[i], c_de2hs[i]);
        hs_run[i]++;
      end else if (!pv_hs[i]) begin
        chk(tg(i, ".hs_len"), hs_run[i], c_hslen[i]);
        hs_run[i] = 0;
      end
      if (!vs[i]) vs_run[i]++;
      else if (!pv_vs[i]) begin
        chk(tg(i, ".vs_len"), vs_run[i], c_vslen[i]);
        vs_run[i] = 0;
      end
      if (fs[i]) begin
        if (f_last[i] >= 0) chk(tg(i, ".frame_per"), cyc - f_last[i], c_frame[i]);
        f_last[i] = cyc;
      end
    end
    pv_req[i] = req[i]; pv_de[i] = de[i]; pv_hs[i] = hs[i]; pv_vs[i] = vs[i];
    // model: raster position this cycle -> next-cycle request, pins FETCH_LAT+2 later
    h   = t[i] % p_ht[i];
    v   = t[i] / p_ht[i];
    act = en && (h < p_ha[i]) && (v < p_va[i]);
    ereq[i] = act;
    efs[i]  = act && (t[i] == 0);
    if (act) begin
      ex[i] = 12'(h);
      ey[i] = 12'(v);
    end
    e.due = cyc + p_fl[i] + 2;
    e.de  = act;
    e.hs  = !((h >= p_ha[i] + p_hfp[i]) && (h < p_ha[i] + p_hfp[i] + p_hs[i]));
    e.vs  = !((v >= p_va[i] + p_vfp[i]) && (v < p_va[i] + p_vfp[i] + p_vs[i]));
    e.rgb = act ? exp_pix(h, v, p_ha[i]) : 16'h0000;
    sbq[i].push_back(e);
    t[i] = en ? (t[i] + 1) % (p_ht[i] * p_vt[i]) : 0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon(i);
  end

  // bounded wait for a given request column on the full-size instance
  task automatic wait_x(input logic [11:0] x, input string tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      @(negedge clk);
      if (req[0] && rx[0] == x) hit = 1'b1;
    end
    chk(tag, hit, 1);
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    // idle with en low: model expects no requests and idle pins
    repeat (1000) @(posedge clk);

    // free run with interval measurements
    #1 en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r_rise[i] = -1; d_rise[i] = -1; f_last[i] = -1;
      de_run[i] = 0; hs_run[i] = 0; vs_run[i] = 0;
    end
    meas_on = 1'b1;
    repeat (2500) @(posedge clk);
    #1 meas_on = 1'b0;

    // drop en with the counter at column 300, restart 50 cycles later
    wait_x(12'd298, "wait_col298");
    @(posedge clk);
    #1 en = 1'b0;
    repeat (50) @(posedge clk);
    #1 en = 1'b1;
    repeat (1500) @(posedge clk);

    // async reset with the counter at column 400
    wait_x(12'd399, "wait_col399");
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(tg(i, ".ar_req"), req[i], 0);
      chk(tg(i, ".ar_x"),   rx[i], 0);
      chk(tg(i, ".ar_fs"),  fs[i], 0);
      chk(tg(i, ".ar_de"),  de[i], 0);
      chk(tg(i, ".ar_hs"),  hs[i], 1);
      chk(tg(i, ".ar_vs"),  vs[i], 1);
      chk(tg(i, ".ar_rgb"), rgb[i], 0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2000) @(posedge clk);

    // random en toggling
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1 en = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 60)) @(posedge clk);
    end
    @(posedge clk);
    #1 en = 1'b1;
    repeat (300) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
